// File: rtl/ov_capture_param.sv
// OV-series DVP capture front end: RGB565 or YUYV-luma input, optional 2:1
// decimation, enable-gated frames, frame counter and line-length checking.
module ov_capture_param #(
   parameter int H_ACTIVE = 320,
   parameter int V_ACTIVE = 240,
   parameter int ADDR_W   = 17,
   parameter int CNT_W    = 8
) (
   input  logic              i_pclk,
   input  logic              i_rst,
   input  logic              i_vsync,
   input  logic              i_href,
   input  logic [7:0]        i_d,
   input  logic              i_enable,
   input  logic              i_mode,
   input  logic              i_decim,
   output logic [ADDR_W-1:0] o_addr,
   output logic [15:0]       o_dout,
   output logic              o_we,
   output logic              o_frame_done,
   output logic [CNT_W-1:0]  o_frame_cnt,
   output logic              o_line_err
);

   localparam int XW = $clog2(H_ACTIVE + 2);
   localparam int YW = $clog2(V_ACTIVE + 1);
   localparam int AMAX_FULL = H_ACTIVE * V_ACTIVE - 1;
   localparam int AMAX_DEC  = (H_ACTIVE / 2) * (V_ACTIVE / 2) - 1;

   logic          r_vsync_q;
   logic          r_href_q;
   logic [XW-1:0] r_x;
   logic [YW-1:0] r_y;
   logic          r_phase;
   logic [7:0]    r_hi;
   logic          r_mode;
   logic          r_decim;
   logic          r_active;

   logic              w_vs_fall;
   logic              w_vs_rise;
   logic              w_hr_fall;
   logic              w_line;
   logic              w_line_end;
   logic              w_pix_done;
   logic              w_x_ok;
   logic              w_y_ok;
   logic              w_keep;
   logic              w_store;
   logic [15:0]       w_pixel;
   logic [ADDR_W-1:0] w_addr_max;

   assign w_vs_fall  = r_vsync_q & ~i_vsync;
   assign w_vs_rise  = ~r_vsync_q & i_vsync;
   assign w_hr_fall  = r_href_q & ~i_href;
   assign w_line     = ~i_vsync & i_href;
   assign w_line_end = w_hr_fall & ~i_vsync;

   // RGB565 completes on the second byte, grey on the Y (first) byte
   assign w_pix_done = w_line & (r_mode ? ~r_phase : r_phase);
   assign w_pixel    = r_mode ? {i_d[7:3], i_d[7:2], i_d[7:3]}
                              : {r_hi, i_d};

   assign w_x_ok  = r_x < XW'(H_ACTIVE);
   assign w_y_ok  = r_y < YW'(V_ACTIVE);
   assign w_keep  = ~r_decim | (~r_x[0] & ~r_y[0]);
   assign w_store = w_pix_done & r_active & w_x_ok & w_y_ok & w_keep
                    & ~w_vs_fall;

   assign w_addr_max = r_decim ? ADDR_W'(AMAX_DEC) : ADDR_W'(AMAX_FULL);

   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         r_vsync_q <= 1'b0;
         r_href_q  <= 1'b0;
      end else begin
         r_vsync_q <= i_vsync;
         r_href_q  <= i_href;
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         r_active <= 1'b0;
         r_mode   <= 1'b0;
         r_decim  <= 1'b0;
      end else if (w_vs_fall) begin
         r_active <= i_enable;
         r_mode   <= i_mode;
         r_decim  <= i_decim;
      end else if (w_vs_rise) begin
         r_active <= 1'b0;
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         r_x     <= '0;
         r_y     <= '0;
         r_phase <= 1'b0;
         r_hi    <= '0;
      end else if (w_vs_fall) begin
         r_x     <= '0;
         r_y     <= '0;
         r_phase <= 1'b0;
      end else if (w_line) begin
         r_phase <= ~r_phase;
         if (~r_phase)
            r_hi <= i_d;
         if (w_pix_done && r_x != XW'(H_ACTIVE + 1))
            r_x <= r_x + XW'(1);
      end else begin
         // a dangling odd byte is dropped simply by clearing the phase
         r_phase <= 1'b0;
         if (w_line_end) begin
            r_x <= '0;
            if (r_y != YW'(V_ACTIVE))
               r_y <= r_y + YW'(1);
         end
      end
   end

   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         o_we   <= 1'b0;
         o_dout <= '0;
      end else begin
         o_we <= w_store;
         if (w_store)
            o_dout <= w_pixel;
      end
   end

   // addr advances after each write but parks on the last frame location
   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst)
         o_addr <= '0;
      else if (w_vs_fall)
         o_addr <= '0;
      else if (o_we && o_addr != w_addr_max)
         o_addr <= o_addr + ADDR_W'(1);
   end

   always_ff @(posedge i_pclk or posedge i_rst) begin
      if (i_rst) begin
         o_frame_done <= 1'b0;
         o_frame_cnt  <= '0;
         o_line_err   <= 1'b0;
      end else begin
         o_frame_done <= w_vs_rise & r_active;
         if (w_vs_rise && r_active)
            o_frame_cnt <= o_frame_cnt + CNT_W'(1);
         o_line_err <= w_line_end & r_active & (r_x != XW'(H_ACTIVE));
      end
   end

endmodule
